mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter sharing the single main-memory block port between the instruction-cache refill path and the data-cache refill/writeback path. It converts two cache-side read/write/busywait handshakes into one serialized memory transaction stream. Its requester-side busywaits feed the cache BUSYWAIT outputs, which stall the IF/ID…MEM/WB pipeline registers.

## Interface
Parameters:
- ADDR_WIDTH, 28, block address width (byte address >> 4)
- DATA_WIDTH, 128, block width in bits
- STARVE_LIMIT, 4, consecutive D grants allowed while I waits (fairness build only)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- I_READ  in  1  I-cache block read request, held until I_BUSYWAIT low
- I_ADDRESS  in  ADDR_WIDTH  I-cache block address
- I_READDATA  out  DATA_WIDTH  registered fetched block
- I_BUSYWAIT  out  1  I-side stall
- D_READ, D_WRITE  in  1 each  D-cache block read / writeback requests
- D_ADDRESS  in  ADDR_WIDTH  D-cache block address
- D_WRITEDATA  in  DATA_WIDTH  writeback block
- D_READDATA  out  DATA_WIDTH  registered fetched block
- D_BUSYWAIT  out  1  D-side stall
- MEM_READ, MEM_WRITE  out  1 each  memory commands
- MEM_ADDRESS  out  ADDR_WIDTH; MEM_WRITEDATA  out  DATA_WIDTH
- MEM_READDATA  in  DATA_WIDTH; MEM_BUSYWAIT  in  1

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE_I, RELEASE_D.
- IDLE: D request (D_READ|D_WRITE) wins over I_READ; chosen SERVE_x entered next edge; no request -> stay.
- On entering SERVE_x, latch address, write data and command (D_WRITE wins if D_READ and D_WRITE both high; that combination is illegal from the cache). MEM_* driven from these latches only, so requester input changes mid-transaction are ignored.
- SERVE_x: MEM_READ/MEM_WRITE held high. Completion = MEM_BUSYWAIT sampled low at a rising edge, excluding the first SERVE cycle. On completion of a read, MEM_READDATA captured into x_READDATA; go to RELEASE_x.
- RELEASE_x: MEM_READ = MEM_WRITE = 0; x_BUSYWAIT = 0 for exactly this cycle; next state IDLE.
- x_BUSYWAIT = x request high AND state ≠ RELEASE_x (combinational, so stall asserts in the request cycle). Low when no request.
- Requester drops its request at the edge ending RELEASE_x; a request still high in IDLE is a new transaction.
- x_READDATA holds its value until the next read completion for x; writes leave D_READDATA unchanged.

## Timing
- Reset (RESET low, any time, including mid-transaction): state IDLE, MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA = 0, I_READDATA = D_READDATA = 0, fairness counter = 0, both busywaits 0 while RESET low. Aborted transaction is not resumed; requester re-issues.
- Minimum transaction: request seen at edge N -> SERVE at N..N+1 -> completion at N+2 -> RELEASE N+2..N+3 -> IDLE at N+3. A waiting requester is granted at the edge leaving IDLE, so back-to-back transactions have one IDLE cycle between them.
- Simultaneous I and D requests in IDLE: D first, I served immediately after (unless a new D arrives and the fairness rule does not force I).

## Configuration
- ARB_FAIRNESS_EN defined: a counter increments on each D grant made while I_READ is high, and clears on an I grant. When the counter equals STARVE_LIMIT and I_READ is high, I wins in IDLE. The counter saturates at STARVE_LIMIT.
- Undefined: strict D priority. The counter is not built, and STARVE_LIMIT is unused.

## Structure
- Shared package: state encoding typedef (IDLE, SERVE_I, SERVE_D, RELEASE_I, RELEASE_D), default ADDR_WIDTH/DATA_WIDTH constants shared with the caches.
- One sub-module: arb_fairness_counter (counter and saturate compare), instantiated only under ARB_FAIRNESS_EN.

## Test plan
- Reset mid-SERVE_D (memory model with 5-cycle latency, RESET low at cycle 2): MEM_READ = 0 and busywaits = 0 while low, state IDLE after release; re-issued request completes normally.
- I_READ alone, I_ADDRESS = 28'h0000010, memory returns 128'hA5…A5 after 3 cycles: MEM_ADDRESS = 28'h0000010 during SERVE_I, I_BUSYWAIT low for one cycle, I_READDATA = 128'hA5…A5.
- D_WRITE, D_ADDRESS = 28'h0000020, D_WRITEDATA = 128'h1234: MEM_WRITE high with that data until completion; D_READDATA unchanged.
- I_READ and D_READ asserted on the same cycle: D transaction completes first, then I, with I_BUSYWAIT high throughout the D transaction.
- D_ADDRESS changed to 28'hFFFFFFF mid-SERVE_D: MEM_ADDRESS keeps the latched value.
- ARB_FAIRNESS_EN, STARVE_LIMIT = 4, D requests back-to-back with I_READ held: I granted after the 4th D; strict build never grants I until D idles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the main-memory port arbiter.
//   - arb_state_e      : arbiter FSM state encoding
//   - MEM_ADDR_WIDTH   : default block address width (byte address >> 4)
//   - MEM_DATA_WIDTH   : default block width in bits
// Both width constants are shared with the instruction and data caches.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 28;
  localparam int unsigned MEM_DATA_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE_I   = 3'd1,
    SERVE_D   = 3'd2,
    RELEASE_I = 3'd3,
    RELEASE_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the I-cache, D-cache and main-memory block-port signals.
//
// Handshake: a requester raises x_READ (or D_WRITE) and holds it, together
// with its address/write data, while x_BUSYWAIT is high. x_BUSYWAIT drops for
// exactly one cycle when the block transfer is done; the requester removes
// its request at the clock edge that ends that cycle. On the memory side
// MEM_READ/MEM_WRITE stay high until MEM_BUSYWAIT is sampled low.
//
// Modports:
//   slave  - the arbiter: accepts cache requests, drives the memory commands
//   master - the environment (caches and memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
);

  // I-cache side
  logic                  I_READ;
  logic [ADDR_WIDTH-1:0] I_ADDRESS;
  logic [DATA_WIDTH-1:0] I_READDATA;
  logic                  I_BUSYWAIT;
  // D-cache side
  logic                  D_READ;
  logic                  D_WRITE;
  logic [ADDR_WIDTH-1:0] D_ADDRESS;
  logic [DATA_WIDTH-1:0] D_WRITEDATA;
  logic [DATA_WIDTH-1:0] D_READDATA;
  logic                  D_BUSYWAIT;
  // Memory side
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
  logic [DATA_WIDTH-1:0] MEM_WRITEDATA;
  logic [DATA_WIDTH-1:0] MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/arb_fairness_counter.sv
// -----------------------------------------------------------------------------
// arb_fairness_counter
// Counts data-side grants made while the instruction side is waiting and
// flags starvation once the count reaches LIMIT (where it saturates).
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   inc_i    - D grant issued while I_READ is high
//   clr_i    - I grant issued
//   starve_o - count equals LIMIT: the I side must win the next arbitration
// -----------------------------------------------------------------------------
module arb_fairness_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic starve_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign starve_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single main-memory block port between the I-cache refill path
// and the D-cache refill/writeback path, serialising their transactions.
// The data side has priority; build with ARB_FAIRNESS_EN defined to force an
// instruction grant after STARVE_LIMIT consecutive data grants made while the
// instruction side was waiting.
// Ports:
//   CLK         - clock, rising edge
//   RESET       - asynchronous active-low reset
//   bus         - cache and memory signals (slave modport)
//   dbg_state_o - current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_port_arbiter_if.slave   bus,
  output arb_state_e          dbg_state_o
);

  arb_state_e            state_q, state_d;
  logic                  first_q, first_d;   // high during the first SERVE cycle
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic idle, d_req, starve, grant_d, grant_i, mem_done;

  assign idle    = (state_q == IDLE);
  assign d_req   = bus.D_READ | bus.D_WRITE;
  assign grant_d = idle && d_req && !(starve && bus.I_READ);
  assign grant_i = idle && bus.I_READ && !grant_d;
  // The edge closing the first SERVE cycle never completes a transfer.
  assign mem_done = !first_q && !bus.MEM_BUSYWAIT;

`ifdef ARB_FAIRNESS_EN
  arb_fairness_counter #(.LIMIT(STARVE_LIMIT)) u_fairness (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .inc_i    (grant_d && bus.I_READ),
    .clr_i    (grant_i),
    .starve_o (starve)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          first_d = 1'b1;
          wr_d    = bus.D_WRITE;   // a write wins over a simultaneous read
          addr_d  = bus.D_ADDRESS;
          wdata_d = bus.D_WRITEDATA;
        end else if (grant_i) begin
          state_d = SERVE_I;
          first_d = 1'b1;
          wr_d    = 1'b0;
          addr_d  = bus.I_ADDRESS;
          wdata_d = '0;
        end
      end
      SERVE_I: begin
        if (mem_done) begin
          state_d   = RELEASE_I;
          i_rdata_d = bus.MEM_READDATA;
        end
      end
      SERVE_D: begin
        if (mem_done) begin
          state_d = RELEASE_D;
          if (!wr_q) d_rdata_d = bus.MEM_READDATA;
        end
      end
      RELEASE_I, RELEASE_D: state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  logic serving;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  // Memory commands come only from the latched copies, so requester inputs
  // that move mid-transaction have no effect.
  assign bus.MEM_READ      = serving && !wr_q;
  assign bus.MEM_WRITE     = serving && wr_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;

  // Combinational so the pipeline stalls in the very cycle a request appears.
  assign bus.I_BUSYWAIT = RESET && bus.I_READ && (state_q != RELEASE_I);
  assign bus.D_BUSYWAIT = RESET && d_req && (state_q != RELEASE_D);
  assign bus.I_READDATA = i_rdata_q;
  assign bus.D_READDATA = d_rdata_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a memory responder with programmable
// latency, cache requester tasks, a transaction-level reference model checked
// against the DUT on every falling edge, and literal checks per scenario.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  arb_state_e dbg_state;

  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // ---------------- memory responder ----------------
  int            mem_lat  = 3;
  logic [DW-1:0] mem_data = '0;
  int            mem_cnt  = 0;

  initial begin
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          bus.MEM_BUSYWAIT = 1'b0;
          bus.MEM_READDATA = mem_data;
        end
      end else begin
        mem_cnt          = 0;
        bus.MEM_BUSYWAIT = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // m_owner: 0 = port free, 1 = I transaction, 2 = D transaction
  int            m_owner   = 0;
  bit            m_rel     = 0;  // the one-cycle handback after a transfer
  int            m_age     = 0;  // SERVE cycles already elapsed
  bit            m_wr      = 0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_wdata   = '0;
  logic [DW-1:0] m_irdata  = '0;
  logic [DW-1:0] m_drdata  = '0;
  int            m_dstreak = 0;  // D grants while I waited
  bit            m_force_i;
  bit            m_d_want;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_owner = 0; m_rel = 0; m_age = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_dstreak = 0;
    end else if (m_rel) begin
      m_rel   = 0;
      m_owner = 0;
    end else if (m_owner != 0) begin
      if (m_age >= 1 && !bus.MEM_BUSYWAIT) begin
        if (!m_wr) begin
          if (m_owner == 1) m_irdata = bus.MEM_READDATA;
          else              m_drdata = bus.MEM_READDATA;
        end
        m_rel = 1;
      end else begin
        m_age++;
      end
    end else begin
      m_d_want = bus.D_READ || bus.D_WRITE;
`ifdef ARB_FAIRNESS_EN
      m_force_i = (m_dstreak >= SL);
`else
      m_force_i = 0;
`endif
      m_age = 0;
      if (bus.I_READ && (!m_d_want || m_force_i)) begin
        m_owner = 1; m_wr = 0; m_addr = bus.I_ADDRESS; m_wdata = '0; m_dstreak = 0;
      end else if (m_d_want) begin
        m_owner = 2; m_wr = bus.D_WRITE; m_addr = bus.D_ADDRESS; m_wdata = bus.D_WRITEDATA;
        if (bus.I_READ && m_dstreak < SL) m_dstreak++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_serving;
  always @(negedge CLK) begin
    e_serving = (m_owner != 0) && !m_rel;
    chk("mem_read",  bus.MEM_READ,  e_serving && !m_wr);
    chk("mem_write", bus.MEM_WRITE, e_serving && m_wr);
    if (e_serving) chk("mem_address", bus.MEM_ADDRESS, m_addr);
    if (e_serving && m_wr) chk("mem_writedata", bus.MEM_WRITEDATA, m_wdata);
    chk("i_busywait", bus.I_BUSYWAIT, RESET && bus.I_READ && !(m_rel && m_owner == 1));
    chk("d_busywait", bus.D_BUSYWAIT,
        RESET && (bus.D_READ || bus.D_WRITE) && !(m_rel && m_owner == 2));
    chk("i_readdata", bus.I_READDATA, m_irdata);
    chk("d_readdata", bus.D_READDATA, m_drdata);
  end

  // ---------------- completion order monitor ----------------
  int rel_q[$];
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (RESET && (bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT) rel_q.push_back(2);
      if (RESET && bus.I_READ && !bus.I_BUSYWAIT) rel_q.push_back(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_release(input bit is_d);
    bit done = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK); #1;
      if (is_d ? !bus.D_BUSYWAIT : !bus.I_BUSYWAIT) begin
        done = 1;
        break;
      end
    end
    if (!done) timeout_fail(is_d ? "d_release" : "i_release");
    @(posedge CLK); #1;
    if (is_d) begin
      bus.D_READ  = 1'b0;
      bus.D_WRITE = 1'b0;
    end else begin
      bus.I_READ = 1'b0;
    end
  endtask

  task automatic d_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.D_READ      = !wr;
    bus.D_WRITE     = wr;
    bus.D_ADDRESS   = a;
    bus.D_WRITEDATA = wd;
    wait_release(1);
  endtask

  task automatic i_txn(input logic [AW-1:0] a);
    bus.I_READ    = 1'b1;
    bus.I_ADDRESS = a;
    wait_release(0);
  endtask

  task automatic wait_cmd(input string name);
    bit seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge CLK); #1;
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeout_fail(name);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.I_READ = 1'b0; bus.I_ADDRESS = '0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mem_read",   bus.MEM_READ, 1'b0);
    chk("rst_mem_addr",   bus.MEM_ADDRESS, 28'h0);
    chk("rst_mem_wdata",  bus.MEM_WRITEDATA, 128'h0);
    chk("rst_i_readdata", bus.I_READDATA, 128'h0);
    chk("rst_d_readdata", bus.D_READDATA, 128'h0);
    chk("rst_state",      dbg_state, IDLE);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // I read alone
    mem_lat  = 3;
    mem_data = {16{8'hA5}};
    bus.I_READ    = 1'b1;
    bus.I_ADDRESS = 28'h0000010;
    wait_cmd("i_cmd");
    chk("i_mem_addr", bus.MEM_ADDRESS, 28'h0000010);
    chk("i_mem_read", bus.MEM_READ, 1'b1);
    wait_release(0);
    chk("i_readdata_a5", bus.I_READDATA, {16{8'hA5}});

    // D read, then a D write that must not touch D_READDATA
    mem_data = {16{8'h5A}};
    d_txn(0, 28'h0000008, '0);
    chk("d_readdata_5a", bus.D_READDATA, {16{8'h5A}});
    mem_data = {16{8'hEE}};
    bus.D_WRITE = 1'b1; bus.D_ADDRESS = 28'h0000020; bus.D_WRITEDATA = 128'h1234;
    wait_cmd("d_wr_cmd");
    chk("d_wr_mem_write", bus.MEM_WRITE, 1'b1);
    chk("d_wr_mem_wdata", bus.MEM_WRITEDATA, 128'h1234);
    chk("d_wr_mem_addr",  bus.MEM_ADDRESS, 28'h0000020);
    wait_release(1);
    chk("d_wr_keeps_rdata", bus.D_READDATA, {16{8'h5A}});

    // Simultaneous I and D: D completes first
    mem_lat = 2;
    mem_data = {4{32'h0BADF00D}};
    rel_q.delete();
    fork
      i_txn(28'h0000044);
      d_txn(0, 28'h0000088, '0);
    join
    chk("sim_count",  rel_q.size(), 2);
    chk("sim_first",  rel_q[0], 2);
    chk("sim_second", rel_q[1], 1);

    // Address change mid-SERVE_D is ignored
    mem_lat = 4;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h0000030;
    wait_cmd("addr_cmd");
    @(posedge CLK); #1;
    bus.D_ADDRESS = 28'hFFFFFFF;
    @(posedge CLK); #1;
    chk("latched_addr", bus.MEM_ADDRESS, 28'h0000030);
    chk("latched_read", bus.MEM_READ, 1'b1);
    wait_release(1);

    // Reset in the middle of SERVE_D
    mem_lat = 5;
    mem_data = {8{16'hC3C3}};
    bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h0000040;
    wait_cmd("rst_cmd");
    @(posedge CLK); #1;
    bus.I_READ = 1'b1;
    RESET = 1'b0;
    #1;
    chk("mid_rst_mem_read", bus.MEM_READ, 1'b0);
    chk("mid_rst_d_bw",     bus.D_BUSYWAIT, 1'b0);
    chk("mid_rst_i_bw",     bus.I_BUSYWAIT, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1; bus.D_READ = 1'b0; bus.I_READ = 1'b0;
    @(negedge CLK);
    chk("post_rst_state", dbg_state, IDLE);
    @(posedge CLK); #1;
    d_txn(0, 28'h0000040, '0);
    chk("reissue_rdata", bus.D_READDATA, {8{16'hC3C3}});

    // Back-to-back D with I held
    mem_lat = 1;
    rel_q.delete();
    fork
      i_txn(28'h0000070);
      begin
        for (int k = 0; k < 6; k++) d_txn(0, 28'h0000100 + AW'(k), '0);
      end
    join
    chk("b2b_count", rel_q.size(), 7);
`ifdef ARB_FAIRNESS_EN
    chk("b2b_d4", rel_q[3], 2);
    chk("b2b_i5", rel_q[4], 1);
    chk("b2b_d6", rel_q[5], 2);
`else
    chk("b2b_d6", rel_q[5], 2);
    chk("b2b_i7", rel_q[6], 1);
`endif

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
